// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared size codes, FSM encoding and alignment helpers for the load/store unit
package lsu_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic is_byte(input logic [2:0] size);
    return (size == SZ_B) || (size == SZ_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] size);
    return (size == SZ_H) || (size == SZ_HU);
  endfunction

  // Unknown size codes fall through to the word rule.
  function automatic logic is_aligned(input logic [2:0] size, input logic [1:0] addr_lo);
    if (is_byte(size)) return 1'b1;
    if (is_half(size)) return !addr_lo[0];
    return addr_lo == 2'b00;
  endfunction

  function automatic logic [2:0] beat_count(input logic [2:0] size, input logic [1:0] addr_lo);
    if (is_aligned(size, addr_lo)) return 3'd1;
    if (is_half(size)) return 3'd2;
    return 3'd4;
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// rtl/lsu_extend.sv - sign/zero extension of assembled load data by size code
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  size,
  input  logic [31:0] data_in,
  output logic [31:0] data_out
);

  // Pick the extension rule from the original load size; words pass through.
  always_comb begin
    data_out = data_in;
    case (size)
      SZ_B:    data_out = {{24{data_in[7]}}, data_in[7:0]};
      SZ_H:    data_out = {{16{data_in[15]}}, data_in[15:0]};
      SZ_BU:   data_out = {24'h0, data_in[7:0]};
      SZ_HU:   data_out = {16'h0, data_in[15:0]};
      default: data_out = data_in;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - data-memory initiator that splits misaligned accesses into byte beats
module load_store_unit
  import lsu_pkg::*;
#(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_access_addr,
  output logic [31:0] mem_in,
  output logic        mem_write_en,
  output logic        mem_read_en,
  output logic [2:0]  mem_data_size,
  input  logic [31:0] mem_out
);

  lsu_state_e  state_q, state_d;
  logic [2:0]  beat_q, beat_d;
  logic [2:0]  nbeats_q, nbeats_d;
  logic        split_q, split_d;
  logic        write_q, write_d;
  logic [2:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] asm_next;
  logic [31:0] ext_data;
  logic        req_aligned;

  assign req_aligned = is_aligned(req_size, req_addr[1:0]);

  // State and datapath registers; reset abandons any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_q      <= 3'd0;
      nbeats_q    <= 3'd0;
      split_q     <= 1'b0;
      write_q     <= 1'b0;
      size_q      <= 3'd0;
      addr_q      <= 32'h0;
      wdata_q     <= 32'h0;
      asm_q       <= 32'h0;
      rdata_q     <= 32'h0;
      err_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      nbeats_q    <= nbeats_d;
      split_q     <= split_d;
      write_q     <= write_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      asm_q       <= asm_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  // Assembly view including this beat: whole word when aligned, one byte lane when split.
  always_comb begin
    asm_next = mem_out;
    if (split_q) begin
      asm_next = asm_q;
      asm_next[{beat_q[1:0], 3'b000} +: 8] = mem_out[7:0];
    end
  end

  lsu_extend u_extend (
    .size     (size_q),
    .data_in  (asm_next),
    .data_out (ext_data)
  );

  // Next-state and datapath update; rsp_valid is registered one cycle after entering RESP.
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    nbeats_d    = nbeats_q;
    split_d     = split_q;
    write_d     = write_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    asm_d       = asm_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          write_d  = req_write;
          size_d   = req_size;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          beat_d   = 3'd0;
          asm_d    = 32'h0;
          split_d  = !req_aligned;
          nbeats_d = beat_count(req_size, req_addr[1:0]);
          err_d    = 1'b0;
          if (!req_aligned && !SPLIT_MISALIGNED) begin
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_ACCESS: begin
        beat_d = beat_q + 3'd1;
        if (!write_q) asm_d = asm_next;
        if (beat_q == nbeats_q - 3'd1) begin
          state_d = ST_RESP;
          if (write_q)      rdata_d = 32'h0;
          else if (split_q) rdata_d = ext_data;
          else              rdata_d = asm_next;
        end
      end
      ST_RESP: begin
        rsp_valid_d = 1'b1;
        if (rsp_valid_q && rsp_ready) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Port drive: memory signals only in ACCESS, response fields only while rsp_valid.
  always_comb begin
    req_ready       = (state_q == ST_IDLE) && !rst;
    rsp_valid       = rsp_valid_q;
    rsp_rdata       = rsp_valid_q ? rdata_q : 32'h0;
    rsp_err         = rsp_valid_q ? err_q : 1'b0;
    mem_access_addr = 32'h0;
    mem_in          = 32'h0;
    mem_write_en    = 1'b0;
    mem_read_en     = 1'b0;
    mem_data_size   = 3'd0;
    if (state_q == ST_ACCESS) begin
      mem_access_addr = addr_q + {29'd0, beat_q};
      mem_write_en    = write_q;
      mem_read_en     = !write_q;
      if (split_q) begin
        mem_data_size = write_q ? SZ_B : SZ_BU;
        if (write_q) begin
          case (beat_q[1:0])
            2'd0:    mem_in = {24'h0, wdata_q[7:0]};
            2'd1:    mem_in = {24'h0, wdata_q[15:8]};
            2'd2:    mem_in = {24'h0, wdata_q[23:16]};
            default: mem_in = {24'h0, wdata_q[31:24]};
          endcase
        end
      end else begin
        mem_data_size = size_q;
        mem_in        = write_q ? wdata_q : 32'h0;
      end
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;

  logic        clk;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] mem_access_addr, mem_in, mem_out;
  logic        mem_write_en, mem_read_en;
  logic [2:0]  mem_data_size;

  logic        ns_req_valid, ns_req_ready, ns_rsp_valid, ns_rsp_ready, ns_rsp_err;
  logic [31:0] ns_rsp_rdata, ns_mem_access_addr, ns_mem_in, ns_mem_out;
  logic        ns_mem_write_en, ns_mem_read_en;
  logic [2:0]  ns_mem_data_size;
  logic        ns_en_seen;

  int checks;
  int failures;

  logic [7:0]  mem [0:255];
  logic        mem_clr, poke_en;
  logic [7:0]  poke_addr, poke_data;
  logic [7:0]  ma, h0, h1, w0, w1, w2, w3;

  logic [31:0] log_addr [0:15];
  logic [31:0] log_din  [0:15];
  logic [2:0]  log_size [0:15];
  logic        log_we   [0:15];
  int          log_n;
  logic        log_clr;

  load_store_unit #(.SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_access_addr(mem_access_addr), .mem_in(mem_in), .mem_write_en(mem_write_en),
    .mem_read_en(mem_read_en), .mem_data_size(mem_data_size), .mem_out(mem_out)
  );

  load_store_unit #(.SPLIT_MISALIGNED(1'b0)) dut_ns (
    .clk(clk), .rst(rst),
    .req_valid(ns_req_valid), .req_ready(ns_req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(ns_rsp_valid), .rsp_ready(ns_rsp_ready), .rsp_rdata(ns_rsp_rdata), .rsp_err(ns_rsp_err),
    .mem_access_addr(ns_mem_access_addr), .mem_in(ns_mem_in), .mem_write_en(ns_mem_write_en),
    .mem_read_en(ns_mem_read_en), .mem_data_size(ns_mem_data_size), .mem_out(ns_mem_out)
  );

  assign ns_mem_out = 32'h12345678;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DataMemory model: little-endian byte array, aligned halfword/word decode.
  assign ma = mem_access_addr[7:0];
  assign h0 = {ma[7:1], 1'b0};
  assign h1 = {ma[7:1], 1'b1};
  assign w0 = {ma[7:2], 2'b00};
  assign w1 = {ma[7:2], 2'b01};
  assign w2 = {ma[7:2], 2'b10};
  assign w3 = {ma[7:2], 2'b11};

  always_comb begin
    case (mem_data_size)
      3'b000:  mem_out = {{24{mem[ma][7]}}, mem[ma]};
      3'b100:  mem_out = {24'h0, mem[ma]};
      3'b001:  mem_out = {{16{mem[h1][7]}}, mem[h1], mem[h0]};
      3'b101:  mem_out = {16'h0, mem[h1], mem[h0]};
      default: mem_out = {mem[w3], mem[w2], mem[w1], mem[w0]};
    endcase
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
    end else if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (mem_write_en) begin
      case (mem_data_size)
        3'b000: mem[ma] <= mem_in[7:0];
        3'b001: begin mem[h0] <= mem_in[7:0]; mem[h1] <= mem_in[15:8]; end
        default: begin
          mem[w0] <= mem_in[7:0];   mem[w1] <= mem_in[15:8];
          mem[w2] <= mem_in[23:16]; mem[w3] <= mem_in[31:24];
        end
      endcase
    end
  end

  always @(posedge clk) begin
    if (log_clr) begin
      log_n <= 0;
    end else if (!rst && (mem_write_en || mem_read_en) && log_n < 16) begin
      log_addr[log_n] <= mem_access_addr;
      log_din[log_n]  <= mem_in;
      log_size[log_n] <= mem_data_size;
      log_we[log_n]   <= mem_write_en;
      log_n           <= log_n + 1;
    end
  end

  always @(posedge clk) begin
    if (mem_clr) ns_en_seen <= 1'b0;
    else if (ns_mem_read_en || ns_mem_write_en) ns_en_seen <= 1'b1;
  end

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk); @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic clear_log();
    log_clr = 1'b1;
    @(posedge clk); @(negedge clk);
    log_clr = 1'b0;
  endtask

  task automatic do_req(input logic w, input logic [2:0] sz, input logic [31:0] a,
                        input logic [31:0] wd, output int lat,
                        output logic [31:0] rd, output logic er);
    req_valid = 1'b1; req_write = w; req_size = sz; req_addr = a; req_wdata = wd;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    er = rsp_err;
  endtask

  task automatic finish_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_clr = 1'b1; log_clr = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL reset_req_ready got %b want 0", req_ready); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_rsp got v=%b e=%b d=%h want 0", rsp_valid, rsp_err, rsp_rdata); end
    checks++; if (mem_write_en !== 1'b0 || mem_read_en !== 1'b0 || mem_access_addr !== 32'h0 || mem_in !== 32'h0 || mem_data_size !== 3'd0) begin failures++; $display("FAIL reset_mem got we=%b re=%b addr=%h", mem_write_en, mem_read_en, mem_access_addr); end
    rst = 1'b0; mem_clr = 1'b0; log_clr = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_release_ready got %b want 1", req_ready); end
  endtask

  task automatic test_aligned_lw();
    int lat; logic [31:0] rd; logic er;
    poke(8'h40, 8'hBB); poke(8'h41, 8'hAA); poke(8'h42, 8'h99); poke(8'h43, 8'h88);
    clear_log();
    do_req(1'b0, 3'b010, 32'h40, 32'h0, lat, rd, er);
    checks++; if (lat != 2) begin failures++; $display("FAIL lw_latency got %0d want 2", lat); end
    checks++; if (rd !== 32'h8899AABB || er !== 1'b0) begin failures++; $display("FAIL lw_data got %h err=%b want 8899aabb", rd, er); end
    checks++; if (log_n != 1 || log_addr[0] !== 32'h40 || log_size[0] !== 3'b010 || log_we[0] !== 1'b0) begin failures++; $display("FAIL lw_beats got n=%0d addr=%h size=%b want 1 beat 40 010", log_n, log_addr[0], log_size[0]); end
    finish_rsp();
    checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin failures++; $display("FAIL lw_return_idle got ready=%b valid=%b want 1 0", req_ready, rsp_valid); end
  endtask

  task automatic test_misaligned_sw();
    int lat; logic [31:0] rd; logic er;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'h44; exp_b[1] = 8'h33; exp_b[2] = 8'h22; exp_b[3] = 8'h11;
    clear_log();
    do_req(1'b1, 3'b010, 32'h41, 32'h11223344, lat, rd, er);
    checks++; if (lat != 5) begin failures++; $display("FAIL sw_latency got %0d want 5", lat); end
    checks++; if (rd !== 32'h0 || er !== 1'b0) begin failures++; $display("FAIL sw_rsp got %h err=%b want 0", rd, er); end
    checks++; if (log_n != 4) begin failures++; $display("FAIL sw_beat_count got %0d want 4", log_n); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_addr[i] !== 32'h41 + i || log_size[i] !== 3'b000 || log_din[i][7:0] !== exp_b[i] || log_we[i] !== 1'b1)
        begin failures++; $display("FAIL sw_beat%0d got addr=%h size=%b din=%h want %h 000 %h", i, log_addr[i], log_size[i], log_din[i][7:0], 32'h41 + i, exp_b[i]); end
    end
    finish_rsp();
    do_req(1'b0, 3'b010, 32'h40, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h223344BB) begin failures++; $display("FAIL sw_readback_lw got %h want 223344bb", rd); end
    finish_rsp();
    do_req(1'b0, 3'b000, 32'h44, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h00000011 || lat != 2) begin failures++; $display("FAIL sw_readback_lb got %h lat=%0d want 00000011 lat 2", rd, lat); end
    finish_rsp();
  endtask

  task automatic test_misaligned_lh();
    int lat; logic [31:0] rd; logic er;
    poke(8'h43, 8'hFE); poke(8'h44, 8'h80);
    clear_log();
    do_req(1'b0, 3'b001, 32'h43, 32'h0, lat, rd, er);
    checks++; if (lat != 3) begin failures++; $display("FAIL lh_latency got %0d want 3", lat); end
    checks++; if (rd !== 32'hFFFF80FE) begin failures++; $display("FAIL lh_sign got %h want ffff80fe", rd); end
    checks++; if (log_n != 2 || log_addr[0] !== 32'h43 || log_addr[1] !== 32'h44 || log_size[0] !== 3'b100 || log_size[1] !== 3'b100)
      begin failures++; $display("FAIL lh_beats got n=%0d %h/%b %h/%b want 2 beats 43,44 size 100", log_n, log_addr[0], log_size[0], log_addr[1], log_size[1]); end
    finish_rsp();
    do_req(1'b0, 3'b101, 32'h43, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'h000080FE) begin failures++; $display("FAIL lhu_zero got %h want 000080fe", rd); end
    finish_rsp();
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] rd; logic er;
    do_req(1'b0, 3'b010, 32'h40, 32'h0, lat, rd, er);
    checks++; if (rd !== 32'hFE3344BB) begin failures++; $display("FAIL bp_data got %h want fe3344bb", rd); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFE3344BB || req_ready !== 1'b0 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0 || mem_access_addr !== 32'h0)
        begin failures++; $display("FAIL bp_hold%0d got v=%b d=%h rdy=%b re=%b we=%b want 1 fe3344bb 0 0 0", i, rsp_valid, rsp_rdata, req_ready, mem_read_en, mem_write_en); end
    end
    finish_rsp();
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin failures++; $display("FAIL bp_release got v=%b rdy=%b want 0 1", rsp_valid, req_ready); end
  endtask

  task automatic test_reset_mid_store();
    logic bad;
    poke(8'h51, 8'h00); poke(8'h52, 8'h00); poke(8'h53, 8'h00); poke(8'h54, 8'h00);
    clear_log();
    req_valid = 1'b1; req_write = 1'b1; req_size = 3'b010; req_addr = 32'h51; req_wdata = 32'hAABBCCDD;
    @(posedge clk); @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    checks++; if (mem_write_en !== 1'b1 || mem_access_addr !== 32'h53) begin failures++; $display("FAIL rst_mid_beat2 got we=%b addr=%h want 1 53", mem_write_en, mem_access_addr); end
    rst = 1'b1;
    #1;
    checks++; if (mem_write_en !== 1'b0 || req_ready !== 1'b0 || rsp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_async got we=%b rdy=%b v=%b want 0 0 0", mem_write_en, req_ready, rsp_valid); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0 || mem_write_en !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin failures++; $display("FAIL rst_mid_quiet got activity=%b want 0", bad); end
    checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got %b want 1", req_ready); end
    checks++; if (mem[8'h51] !== 8'hDD || mem[8'h52] !== 8'hCC || mem[8'h53] !== 8'h00 || mem[8'h54] !== 8'h00)
      begin failures++; $display("FAIL rst_mid_mem got %h %h %h %h want dd cc 00 00", mem[8'h51], mem[8'h52], mem[8'h53], mem[8'h54]); end
    checks++; if (log_n != 2) begin failures++; $display("FAIL rst_mid_beats got %0d want 2", log_n); end
  endtask

  task automatic test_no_split();
    int lat; logic [31:0] rd;
    ns_req_valid = 1'b1; req_write = 1'b0; req_size = 3'b010; req_addr = 32'h42; req_wdata = 32'h0;
    @(posedge clk); @(negedge clk);
    ns_req_valid = 1'b0;
    lat = 0;
    while (!ns_rsp_valid && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
    checks++; if (lat != 1) begin failures++; $display("FAIL ns_err_latency got %0d want 1", lat); end
    checks++; if (ns_rsp_err !== 1'b1 || ns_rsp_rdata !== 32'h0) begin failures++; $display("FAIL ns_err_rsp got err=%b d=%h want 1 0", ns_rsp_err, ns_rsp_rdata); end
    @(posedge clk); @(negedge clk);
    checks++; if (ns_rsp_valid !== 1'b1 || ns_rsp_err !== 1'b1) begin failures++; $display("FAIL ns_err_hold got v=%b err=%b want 1 1", ns_rsp_valid, ns_rsp_err); end
    ns_rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ns_rsp_ready = 1'b0;
    checks++; if (ns_en_seen !== 1'b0) begin failures++; $display("FAIL ns_no_mem got %b want 0", ns_en_seen); end
    checks++; if (ns_req_ready !== 1'b1) begin failures++; $display("FAIL ns_idle got %b want 1", ns_req_ready); end
    ns_req_valid = 1'b1; req_addr = 32'h40;
    @(posedge clk); @(negedge clk);
    ns_req_valid = 1'b0;
    lat = 0;
    while (!ns_rsp_valid && lat < 20) begin @(posedge clk); @(negedge clk); lat++; end
    rd = ns_rsp_rdata;
    checks++; if (lat != 2 || rd !== 32'h12345678 || ns_rsp_err !== 1'b0) begin failures++; $display("FAIL ns_aligned got lat=%0d d=%h err=%b want 2 12345678 0", lat, rd, ns_rsp_err); end
    ns_rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    ns_rsp_ready = 1'b0;
  endtask

  initial begin
    checks = 0; failures = 0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    rsp_ready = 1'b0; ns_req_valid = 1'b0; ns_rsp_ready = 1'b0;
    poke_en = 1'b0; poke_addr = 8'h0; poke_data = 8'h0;
    mem_clr = 1'b1; log_clr = 1'b1; rst = 1'b1;
    test_reset();
    test_aligned_lw();
    test_misaligned_sw();
    test_misaligned_lh();
    test_backpressure();
    test_reset_mid_store();
    test_no_split();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
